// File: rtl/hazard_scoreboard.sv
// Register-hazard scoreboard and issue controller for the MIPS32 decode stage.
// Counts in-flight writes per register, gates issue on operand/destination hazards, and handles drain.
module hazard_scoreboard #(
  parameter int CNT_W   = 2,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_valid,
  input  logic [5:0]         id_opcode,
  input  logic [4:0]         id_rs,
  input  logic [4:0]         id_rt,
  input  logic [4:0]         id_dest,
  output logic               id_ready,
  output logic               issue,
  input  logic               wb_valid,
  input  logic [4:0]         wb_reg,
  input  logic               flush,
  input  logic               drain_req,
  output logic               drain_done,
  output logic [31:0]        busy_vec,
  output logic               wb_underflow,
  output logic [STALL_W-1:0] stall_count,
  output logic [1:0]         dbg_state
);

  // Handshake: an instruction transfers on a cycle where id_valid and id_ready are both high
  // (issue); decode holds its fields stable until then, and id_ready never depends on id_valid.
  typedef enum logic [1:0] {
    RUN       = 2'd0,
    DRAIN     = 2'd1,
    DONE      = 2'd2,
    IDLE_HOLD = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt [32];
  logic             is_rtype, is_itype, writes;
  logic             src_hazard, dest_block, all_idle;

  assign is_rtype = (id_opcode <= 6'd5);
  assign is_itype = (id_opcode >= 6'd8) && (id_opcode <= 6'd12);
  assign writes   = is_rtype || is_itype;

  always_comb begin
    busy_vec = '0;
    for (int i = 1; i < 32; i++) busy_vec[i] = (cnt[i] != '0);
  end

  assign all_idle = (busy_vec == 32'd0);

  // busy_vec[0] is constant 0, so register 0 never shows up as a hazard.
  assign src_hazard = ((is_rtype || is_itype) && busy_vec[id_rs]) ||
                      (is_rtype && busy_vec[id_rt]);
  assign dest_block = writes && (id_dest != 5'd0) && (cnt[id_dest] == CNT_MAX);

  assign id_ready  = (state == RUN) && !flush && !src_hazard && !dest_block;
  assign issue     = id_valid && id_ready;
  assign dbg_state = state;

  // A same-cycle issue and writeback on one register cancel out.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < 32; i++) cnt[i] <= '0;
    end else begin
      cnt[0] <= '0;
      for (int i = 1; i < 32; i++) begin
        if (issue && writes && (id_dest == 5'(i)) && !(wb_valid && (wb_reg == 5'(i))))
          cnt[i] <= cnt[i] + CNT_W'(1);
        else if (!(issue && writes && (id_dest == 5'(i))) && wb_valid &&
                 (wb_reg == 5'(i)) && (cnt[i] != '0))
          cnt[i] <= cnt[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      wb_underflow <= 1'b0;
    else if (!flush && wb_valid && (wb_reg != 5'd0) && (cnt[wb_reg] == '0))
      wb_underflow <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      stall_count <= '0;
    else if (id_valid && !id_ready && (stall_count != '1))
      stall_count <= stall_count + STALL_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    drain_done = 1'b0;
    case (state)
      RUN:       if (drain_req) state_nxt = DRAIN;
      DRAIN:     if (all_idle || flush) state_nxt = DONE;
      DONE: begin
        drain_done = 1'b1;
        state_nxt  = drain_req ? IDLE_HOLD : RUN;
      end
      IDLE_HOLD: if (!drain_req) state_nxt = RUN;
      default:   state_nxt = RUN;
    endcase
  end

endmodule
